// File: rtl/quadram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port quad RAM, with a
// full-RAM zero-fill sequencer that takes priority over both requesters.
module quadram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  input  logic                  a_req,
  input  logic [3:0]            a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic [3:0]            b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // state | meaning
  // IDLE  | arbitrate A/B requests, start a fill on clr_start
  // CLEAR | write zero to every RAM word, one per cycle, requesters stalled
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  ptr_b, ptr_b_nxt;
  logic                  done_nxt;
  logic                  a_rv_nxt, b_rv_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr_b    <= 1'b0;
      clr_done <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr_b    <= ptr_b_nxt;
      clr_done <= done_nxt;
      a_rvalid <= a_rv_nxt;
      b_rvalid <= b_rv_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_b_nxt = ptr_b;
    done_nxt  = 1'b0;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    ram_addr  = '0;
    ram_din   = '0;
    case (state)
      CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 4'hF;
        ram_addr = cnt;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        // grants are combinational from the requests, so hold them off in reset
        end else if (rst_n) begin
          if (a_req && (!b_req || !ptr_b)) begin
            a_gnt = 1'b1;
          end else if (b_req) begin
            b_gnt = 1'b1;
          end
        end
        if (a_gnt) begin
          ram_en    = 1'b1;
          ram_we    = a_we;
          ram_addr  = a_addr;
          ram_din   = a_wdata;
          ptr_b_nxt = 1'b1;
        end else if (b_gnt) begin
          ram_en    = 1'b1;
          ram_we    = b_we;
          ram_addr  = b_addr;
          ram_din   = b_wdata;
          ptr_b_nxt = 1'b0;
        end
      end
    endcase
    a_rv_nxt = a_gnt && (a_we == 4'h0);
    b_rv_nxt = b_gnt && (b_we == 4'h0);
  end

  assign clr_busy = (state == CLEAR);
  assign rdata    = ram_dout;

endmodule

// File: doc/quadram_arbiter.md
QUADRAM_ARBITER -- requirements
Module: quadram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, word address width of the shared 2048x32 quad RAM.
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clr_start  input  1  one-cycle pulse requesting a full-RAM zero fill.
REQ-006 clr_busy  output  1  high while the zero fill runs.
REQ-007 clr_done  output  1  one-cycle pulse after the last fill write.
REQ-008 a_req  input  1  requester A access request; held until granted.
REQ-009 a_we  input  4  requester A byte write enables; 0 = read.
REQ-010 a_addr  input  ADDR_WIDTH  requester A word address.
REQ-011 a_wdata  input  DATA_WIDTH  requester A write data.
REQ-012 a_gnt  output  1  requester A access accepted this cycle.
REQ-013 a_rvalid  output  1  read data for A valid on rdata.
REQ-014 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  same widths and meanings as A, for requester B.
REQ-015 rdata  output  DATA_WIDTH  shared read data, meaningful only when a_rvalid or b_rvalid.
REQ-016 ram_en  output  1  RAM enable.
REQ-017 ram_we  output  4  RAM byte write enables.
REQ-018 ram_addr  output  ADDR_WIDTH  RAM word address.
REQ-019 ram_din  output  DATA_WIDTH  RAM write data.
REQ-020 ram_dout  input  DATA_WIDTH  RAM read data, valid one cycle after an enabled read.

Function
REQ-021 FSM states: IDLE, CLEAR; reset enters IDLE.
REQ-022 IDLE, clr_start=1 -> CLEAR next cycle, fill counter=0; clr_start in CLEAR ignored.
REQ-023 CLEAR, every cycle: ram_en=1, ram_we=4'hF, ram_din=0, ram_addr=counter, counter+1; after counter=2047 write -> IDLE, clr_done=1 for exactly that next cycle; 2048 cycles total, no wrap.
REQ-024 a_gnt=b_gnt=0 throughout CLEAR and in the cycle clr_start is sampled in IDLE (fill has priority).
REQ-025 IDLE arbitration combinational same cycle: single requester granted immediately; both requesting -> grant per round-robin pointer.
REQ-026 Pointer favours A out of reset; after any grant pointer favours the other requester; pointer unchanged when no grant.
REQ-027 On grant: ram_en=1, ram_we/ram_addr/ram_din driven from the winner's we/addr/wdata in the same cycle.
REQ-028 No grant and not CLEAR: ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-029 Granted read (we=0): winner's rvalid=1 for exactly the next cycle, rdata=ram_dout; granted write produces no rvalid.
REQ-030 Throughput one access per cycle; back-to-back grants allowed; rvalid of a read granted the cycle before clr_start still issues.
REQ-031 a_rvalid and b_rvalid never high together; gnt never high without matching req.

Reset
REQ-032 rst_n low asynchronously forces: IDLE, counter=0, pointer favours A, clr_busy=0, clr_done=0, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, ram_en=0, ram_we=0.
REQ-033 Reset mid-CLEAR aborts the fill with no clr_done; RAM contents unspecified; reset mid-read suppresses the pending rvalid.

Verification
REQ-034 A alone: a_we=0, a_addr=0x123 -> a_gnt=1 same cycle, ram_addr=0x123, a_rvalid=1 next cycle with rdata=ram_dout.
REQ-035 A and B both request reads 4 consecutive cycles from reset -> grants A,B,A,B; each rvalid one cycle after its grant.
REQ-036 clr_start pulse -> clr_busy=1 for 2048 cycles, ram_addr 0..2047 with ram_we=4'hF, ram_din=0, then clr_done=1 one cycle; reads afterwards return 0.
REQ-037 B write 0xDEADBEEF, we=4'hF at 0x7FF concurrent with clr_start -> b_gnt=0 that cycle, b_gnt=1 first cycle after fill completes.
REQ-038 rst_n low at fill counter=1000 -> outputs at reset values immediately, clr_done never asserts, next clr_start restarts at address 0.
